instr_serializer: RTL and testbench

Transmit side of the TPU instruction interface. Accepts one instr_type per valid/ready handshake and packs it into the canonical 80-bit layout: buff_addr[79:56], acc_addr[55:40], length[39:8], opcode[7:0]. Streams the packed instruction LSB-first as BUS_WIDTH-bit beats over a valid/ready bus toward the instruction FIFO / decoder. It is the inverse of the package bit-to-instruction decode.

---
 rtl/tpu_pkg.sv | 33 +++
 rtl/instr_serializer.sv | 140 ++++++++++++++
 tb/tb_instr_serializer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU instruction types: the 80-bit instruction layout, its pack/unpack
// helpers and the serializer state encoding.
package tpu_pkg;

    localparam int INSTR_WIDTH = 80;

    typedef struct packed {
        logic [23:0] buff_addr;
        logic [15:0] acc_addr;
        logic [31:0] length;
        logic [7:0]  opcode;
    } instr_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2
    } ser_state_type;

    function automatic instr_type bit_to_instr(input logic [INSTR_WIDTH-1:0] b);
        instr_type r;
        r.buff_addr = b[79:56];
        r.acc_addr  = b[55:40];
        r.length    = b[39:8];
        r.opcode    = b[7:0];
        return r;
    endfunction

    function automatic logic [INSTR_WIDTH-1:0] instr_to_bit(input instr_type i);
        return {i.buff_addr, i.acc_addr, i.length, i.opcode};
    endfunction

endpackage

// File: rtl/instr_serializer.sv
// Packs an instruction into 80 bits and streams it LSB-first as BUS_WIDTH beats.
// Optional trailing XOR checksum beat when INSTR_SER_CHECKSUM_EN is defined.
module instr_serializer
    import tpu_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  instr_type            in_instr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic [15:0]          instr_count
);

    localparam int NUM_BEATS = (INSTR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int SHIFT_W   = NUM_BEATS * BUS_WIDTH;
    localparam int BEAT_W    = $clog2(NUM_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    generate
        if (BUS_WIDTH != 8 && BUS_WIDTH != 16 && BUS_WIDTH != 32) begin : g_bad_width
            $error("instr_serializer: BUS_WIDTH must be 8, 16 or 32");
        end
    endgenerate

    ser_state_type        r_state;
    ser_state_type        w_next;
    logic [BEAT_W-1:0]    r_beat;
    logic [SHIFT_W-1:0]   r_shift;
    logic [15:0]          r_count;
    logic                 w_last_data;
    logic                 w_final_beat;
    logic                 w_done;
    logic                 w_accept;
`ifdef INSTR_SER_CHECKSUM_EN
    logic [BUS_WIDTH-1:0] r_csum;
`endif

    assign w_last_data = (r_state == SEND) && (r_beat == LAST_BEAT);
`ifdef INSTR_SER_CHECKSUM_EN
    assign w_final_beat = (r_state == CHK);
`else
    assign w_final_beat = w_last_data;
`endif
    assign w_done   = w_final_beat && out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = SEND;
                end
            end
            SEND: begin
                if (out_ready && r_beat == LAST_BEAT) begin
`ifdef INSTR_SER_CHECKSUM_EN
                    w_next = CHK;
`else
                    w_next = in_valid ? SEND : IDLE;
`endif
                end
            end
`ifdef INSTR_SER_CHECKSUM_EN
            CHK: begin
                if (out_ready) begin
                    w_next = in_valid ? SEND : IDLE;
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) || w_done;
        out_valid = (r_state != IDLE);
        busy      = (r_state != IDLE);
        out_last  = w_final_beat;
        out_data  = '0;
        case (r_state)
            SEND:    out_data = r_shift[BUS_WIDTH-1:0];
`ifdef INSTR_SER_CHECKSUM_EN
            CHK:     out_data = r_csum;
`endif
            default: out_data = '0;
        endcase
    end

    // The shift register always presents the current beat in its low bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat  <= '0;
            r_shift <= '0;
`ifdef INSTR_SER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else if (w_accept) begin
            r_beat  <= '0;
            r_shift <= SHIFT_W'(instr_to_bit(in_instr));
`ifdef INSTR_SER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else if (r_state == SEND && out_ready) begin
            r_shift <= r_shift >> BUS_WIDTH;
            if (!w_last_data) begin
                r_beat <= r_beat + 1'b1;
            end
`ifdef INSTR_SER_CHECKSUM_EN
            r_csum  <= r_csum ^ r_shift[BUS_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_done) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign instr_count = r_count;

endmodule

// File: tb/tb_instr_serializer.sv
// Randomized self-checking bench for instr_serializer against a beat-queue model.
// Honors INSTR_SER_CHECKSUM_EN the same way the design does.
module tb_instr_serializer;
    import tpu_pkg::*;

    localparam int BW  = 32;
    localparam int NB  = (80 + BW - 1) / BW;
`ifdef INSTR_SER_CHECKSUM_EN
    localparam int NBT = NB + 1;
`else
    localparam int NBT = NB;
`endif

    typedef struct {
        logic [BW-1:0] data;
        bit            last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    instr_type     in_instr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic [15:0]   instr_count;

    int            n_total = 0;
    int            n_bad   = 0;
    beat_t         exp_q[$];
    logic [15:0]   model_cnt = '0;
    instr_type     cur;
    instr_type     ref_instr;

    instr_serializer #(.BUS_WIDTH(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_instr   (in_instr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_type rand_instr();
        instr_type r;
        r.buff_addr = 24'($urandom);
        r.acc_addr  = 16'($urandom);
        r.length    = $urandom;
        r.opcode    = 8'($urandom);
        return r;
    endfunction

    // Expected beats for one instruction, derived straight from the field layout.
    task automatic push_expected(input instr_type x);
        logic [127:0]  word;
        logic [BW-1:0] csum;
        beat_t         b;
        word = 128'({x.buff_addr, x.acc_addr, x.length, x.opcode});
        csum = '0;
        for (int i = 0; i < NB; i++) begin
            b.data = BW'(word >> (i * BW));
            csum   = csum ^ b.data;
`ifdef INSTR_SER_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == NB - 1);
`endif
            exp_q.push_back(b);
        end
`ifdef INSTR_SER_CHECKSUM_EN
        b.data = csum;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    // One clock cycle: drive at negedge, check #1 later, advance model for the next posedge.
    task automatic step(input bit iv, input bit ordy);
        bit exp_ir;
        in_valid  = iv;
        out_ready = ordy;
        in_instr  = cur;
        #1;
        exp_ir = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
        check_eq("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        check_eq("busy", 128'(busy), 128'(exp_q.size() != 0));
        check_eq("in_ready", 128'(in_ready), 128'(exp_ir));
        check_eq("instr_count", 128'(instr_count), 128'(model_cnt));
        if (exp_q.size() != 0) begin
            check_eq("out_data", 128'(out_data), 128'(exp_q[0].data));
            check_eq("out_last", 128'(out_last), 128'(exp_q[0].last));
            if (ordy) begin
                if (exp_q[0].last) model_cnt = model_cnt + 16'd1;
                void'(exp_q.pop_front());
            end
        end
        if (iv && exp_ir) begin
            push_expected(cur);
            cur = rand_instr();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        check_eq({tag, "_out_last"}, 128'(out_last), 128'(0));
        check_eq({tag, "_out_data"}, 128'(out_data), 128'(0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(0));
        check_eq({tag, "_count"}, 128'(instr_count), 128'(0));
    endtask

    initial begin
        ref_instr.buff_addr = 24'hABCDEF;
        ref_instr.acc_addr  = 16'h1234;
        ref_instr.length    = 32'h10;
        ref_instr.opcode    = 8'h01;
        cur = ref_instr;

        // Reset state
        @(negedge clk);
        check_reset_outputs("reset");
        check_eq("reset_in_ready", 128'(in_ready), 128'(1));
        rst = 1'b0;
        @(negedge clk);

        // Package layout and round trip
        check_eq("pack_ref", 128'(instr_to_bit(ref_instr)), 128'(80'hABCDEF_1234_00000010_01));
        for (int k = 0; k < 4; k++) begin
            instr_type t;
            t = rand_instr();
            check_eq("roundtrip", 128'(bit_to_instr(instr_to_bit(t))), 128'(t));
            check_eq("pack_rand", 128'(instr_to_bit(t)),
                     128'({t.buff_addr, t.acc_addr, t.length, t.opcode}));
        end

        // Reference instruction, downstream always ready
        cur = ref_instr;
        step(1, 1);
        for (int k = 0; k < NBT + 2; k++) step(0, 1);
        check_eq("ref_count", 128'(instr_count), 128'(1));

        // Backpressure pattern 1,0,0,1,...
        cur = ref_instr;
        step(1, 1);
        for (int k = 0; k < 4 * NBT + 4; k++) step(0, (k % 3) == 0);

        // Back-to-back with in_valid held high across two instructions
        cur = rand_instr();
        for (int k = 0; k < NBT + 1; k++) step(1, 1);
        for (int k = 0; k < NBT + 2; k++) step(0, 1);

        // Asynchronous reset mid-instruction, then a clean restart
        cur = ref_instr;
        step(1, 1);
        step(0, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        model_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        cur = ref_instr;
        step(1, 1);
        for (int k = 0; k < NBT + 2; k++) step(0, 1);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        // Drain
        for (int k = 0; k < 2 * NBT + 2; k++) step(0, 1);
        check_eq("drained", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
